// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data), one-slave arbiter for the SRAM-like bus.
// One transaction outstanding; data has priority, bounded by an inst starvation counter.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  starve_q, starve_d;

    logic        grant_data;
    logic        grant_inst;

    // Data wins unless inst has already waited through STARVE_LIMIT data grants.
    always_comb begin
        grant_data = 1'b0;
        grant_inst = 1'b0;
        if (state_q == IDLE) begin
            if (data_req && (!inst_req || (int'(starve_q) < STARVE_LIMIT))) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            starve_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d = ADDR;
                    owner_d = 1'b1;
                    wr_d    = data_wr;
                    size_d  = data_size;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    // Count only data grants that actually made inst wait; saturate at 7.
                    if (!inst_req) begin
                        starve_d = 3'd0;
                    end else if (starve_q != 3'd7) begin
                        starve_d = starve_q + 3'd1;
                    end
                end else if (grant_inst) begin
                    state_d  = ADDR;
                    owner_d  = 1'b0;
                    wr_d     = inst_wr;
                    size_d   = inst_size;
                    addr_d   = inst_addr;
                    wdata_d  = inst_wdata;
                    starve_d = 3'd0;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        inst_data_ok = (state_q == WAIT) && mem_data_ok && !owner_q;
        data_data_ok = (state_q == WAIT) && mem_data_ok && owner_q;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        mem_req      = (state_q == ADDR);
        mem_wr       = wr_q;
        mem_size     = size_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: a slave model serves requests and a
// scoreboard of expected transactions is checked at mem request and response time.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dmaster;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic txn_t inst_txn(input logic [31:0] rdata);
        txn_t t;
        t.dmaster = 1'b0; t.wr = inst_wr; t.size = inst_size;
        t.addr = inst_addr; t.wdata = inst_wdata; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t data_txn(input logic [31:0] rdata);
        txn_t t;
        t.dmaster = 1'b1; t.wr = data_wr; t.size = data_size;
        t.addr = data_addr; t.wdata = data_wdata; t.rdata = rdata;
        return t;
    endfunction

    // Slave model: accept after `stall` cycles, respond the following cycle.
    task automatic serve(input int stall);
        txn_t e;
        int   waited = 0;
        while (mem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (mem_req !== 1'b1) begin
            check_eq("mem_req_timeout", {31'd0, mem_req}, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check_eq("unexpected_txn", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("mem_addr", mem_addr, e.addr);
        check_eq("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
        check_eq("mem_size", {30'd0, mem_size}, {30'd0, e.size});
        check_eq("mem_wdata", mem_wdata, e.wdata);
        for (int i = 0; i < stall; i++) begin
            check_eq("stall_req", {31'd0, mem_req}, 32'd1);
            check_eq("stall_addr", mem_addr, e.addr);
            check_eq("stall_wdata", mem_wdata, e.wdata);
            check_eq("stall_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
            tick();
        end
        mem_addr_ok = 1'b1;
        settle();
        check_eq("addr_phase_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = e.rdata;
        settle();
        check_eq("wait_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, !e.dmaster});
        check_eq("data_data_ok", {31'd0, data_data_ok}, {31'd0, e.dmaster});
        check_eq("rdata", e.dmaster ? data_rdata : inst_rdata, e.rdata);
        check_eq("wait_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check_eq({tag, "_oks"}, {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  starve_m;
        bit  want_data;
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        tick();
        tick();
        resetn = 1'b1;
        settle();
        check_idle_outputs("reset");
        check_eq("reset_mem_addr", mem_addr, 32'd0);
        check_eq("reset_mem_wdata", mem_wdata, 32'd0);

        // Single inst read
        inst_req = 1; inst_addr = 32'hBFC00000;
        settle();
        check_eq("inst_addr_ok_T", {31'd0, inst_addr_ok}, 32'd1);
        check_eq("data_addr_ok_T", {31'd0, data_addr_ok}, 32'd0);
        exp_q.push_back(inst_txn(32'h3C1D0001));
        tick();
        inst_req = 0;
        serve(0);

        // Simultaneous requests: data write first, inst right after
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_wr = 1; data_addr = 32'h1000; data_wdata = 32'hDEADBEEF; data_size = 2'd2;
        settle();
        check_eq("sim_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check_eq("sim_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        exp_q.push_back(data_txn(32'h0));
        tick();
        data_req = 0; data_wr = 0;
        serve(0);
        settle();
        check_eq("sim_inst_after", {31'd0, inst_addr_ok}, 32'd1);
        exp_q.push_back(inst_txn(32'h11112222));
        tick();
        inst_req = 0;
        serve(0);

        // Starvation: both requesting continuously
        do_reset();
        starve_m = 0;
        inst_req = 1; inst_addr = 32'hBFC00100;
        data_req = 1; data_addr = 32'h2000; data_wdata = 32'h0; data_size = 2'd1;
        for (int g = 0; g < 12; g++) begin
            want_data = (starve_m < 4);
            starve_m  = want_data ? starve_m + 1 : 0;
            settle();
            check_eq($sformatf("starve_grant%0d", g),
                     {30'd0, inst_addr_ok, data_addr_ok}, want_data ? 32'd1 : 32'd2);
            exp_q.push_back(want_data ? data_txn(32'h5000 + g) : inst_txn(32'h6000 + g));
            tick();
            serve(0);
        end
        inst_req = 0; data_req = 0;

        // Slave stall on a data read
        data_req = 1; data_addr = 32'h3004; data_size = 2'd0; data_wdata = 32'hA5A5A5A5;
        settle();
        check_eq("stall_grant", {31'd0, data_addr_ok}, 32'd1);
        exp_q.push_back(data_txn(32'hCAFEF00D));
        tick();
        data_req = 0;
        serve(5);

        // Spurious response in IDLE
        mem_data_ok = 1; mem_rdata = 32'h12345678;
        settle();
        check_idle_outputs("spurious");
        tick();
        mem_data_ok = 0;
        settle();
        check_idle_outputs("spurious_after");
        check_eq("spurious_addr_hold", mem_addr, 32'h3004);

        // Reset while in WAIT, then late response
        inst_req = 1; inst_addr = 32'hBFC00200;
        settle();
        check_eq("rst_grant", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        inst_req = 0;
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0;
        resetn = 0;
        tick();
        resetn = 1;
        mem_data_ok = 1; mem_rdata = 32'hBAD0BAD0;
        settle();
        check_idle_outputs("rst_wait");
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_size", {30'd0, mem_size}, 32'd0);
        tick();
        mem_data_ok = 0;
        settle();
        check_idle_outputs("rst_after");

        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
